psum_accumulator: RTL and testbench

//  Downstream of the PE array. Consumes the per-column psum streams from the array's bottom edge and

---
 rtl/pe_pkg.sv | 26 ++
 rtl/psum_col_fifo.sv | 51 +++++
 rtl/psum_accumulator.sv | 171 +++++++++++++++++
 tb/tb_psum_accumulator.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared fixed-point definitions for the psum datapath: word width, signed data type,
// saturating add and ReLU.
package pe_pkg;

  localparam int TOP_BITS = 2;
  localparam int BOT_BITS = 14;
  localparam int DW       = TOP_BITS + BOT_BITS;

  typedef logic signed [DW-1:0] data_t;

  localparam data_t DATA_MAX = data_t'({1'b0, {(DW-1){1'b1}}});
  localparam data_t DATA_MIN = data_t'({1'b1, {(DW-1){1'b0}}});

  // One guard bit is enough: disagreement between the top two bits of the sum means overflow.
  function automatic data_t sat_add(input data_t a, input data_t b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) return s[DW] ? DATA_MIN : DATA_MAX;
    return data_t'(s[DW-1:0]);
  endfunction

  function automatic data_t relu(input data_t a);
    return a[DW-1] ? data_t'('0) : a;
  endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Per-column synchronous FIFO holding finished pixels. A pop frees a slot in the same cycle,
// so a push into a full FIFO that is also being popped is accepted.
module psum_col_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  end

  // NOTE: storage arrays carry no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates G_NUM_PASSES psum rows per PE column into local row buffers, queues finished
// pixels per column and drains them round-robin as one tagged valid/ready stream.
module psum_accumulator
  import pe_pkg::*;
#(
  parameter int G_ARRAY_WIDTH = 4,
  parameter int G_TOP_BITS    = 2,
  parameter int G_BOT_BITS    = 14,
  parameter int G_IMAGE_WIDTH = 28,
  parameter int G_KERNEL_SIZE = 5,
  parameter int G_NUM_PASSES  = 3,
  parameter int G_FIFO_DEPTH  = 8,
  parameter int G_RELU        = 1,
  localparam int DW_P    = G_TOP_BITS + G_BOT_BITS,
  localparam int OFMAP_W = G_IMAGE_WIDTH - G_KERNEL_SIZE + 1,
  localparam int COL_W   = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1,
  localparam int PX_W    = (OFMAP_W > 1) ? $clog2(OFMAP_W) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic [G_ARRAY_WIDTH-1:0]  psum_vld_i,
  input  logic [G_ARRAY_WIDTH*DW_P-1:0] psum_i,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i,
  output logic [DW_P-1:0]           out_data_o,
  output logic [COL_W-1:0]          out_col_o,
  output logic [PX_W-1:0]           out_px_o,
  output logic [G_ARRAY_WIDTH-1:0]  row_done_o,
  output logic                      ovf_o
);

  localparam int PASS_W = (G_NUM_PASSES > 1) ? $clog2(G_NUM_PASSES) : 1;
  localparam int FW     = DW_P + PX_W;

  logic [G_ARRAY_WIDTH-1:0] fifo_push;
  logic [G_ARRAY_WIDTH-1:0] fifo_pop;
  logic [G_ARRAY_WIDTH-1:0] fifo_full;
  logic [G_ARRAY_WIDTH-1:0] fifo_empty;
  logic [G_ARRAY_WIDTH-1:0] row_done;
  logic [FW-1:0]            fifo_word [G_ARRAY_WIDTH];

  logic                     grant_vld;
  logic [COL_W-1:0]         grant_col;
  logic [FW-1:0]            grant_word;
  logic [COL_W-1:0]         last_col;
  logic                     advance;

  logic                     out_vld_q;
  logic [DW_P-1:0]          out_data_q;
  logic [COL_W-1:0]         out_col_q;
  logic [PX_W-1:0]          out_px_q;
  logic                     ovf_q;

  for (genvar c = 0; c < G_ARRAY_WIDTH; c++) begin : g_col
    logic [PX_W-1:0]   px_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic              done_q;
    data_t             acc [OFMAP_W];
    data_t             psum;
    data_t             sum;
    data_t             res;
    logic              last_px;
    logic              last_pass;

    assign psum      = data_t'(psum_i[c*DW_P +: DW_P]);
    assign last_px   = (px_cnt == PX_W'(OFMAP_W - 1));
    assign last_pass = (pass_cnt == PASS_W'(G_NUM_PASSES - 1));
    assign sum       = (G_NUM_PASSES == 1) ? psum : sat_add(acc[px_cnt], psum);
    assign res       = (G_RELU != 0) ? relu(sum) : sum;

    assign fifo_push[c] = psum_vld_i[c] & last_pass & ~clr_i;
    assign fifo_pop[c]  = advance & grant_vld & (grant_col == COL_W'(c)) & ~clr_i;
    assign row_done[c]  = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        px_cnt   <= '0;
        pass_cnt <= '0;
        done_q   <= 1'b0;
      end else if (clr_i) begin
        px_cnt   <= '0;
        pass_cnt <= '0;
        done_q   <= 1'b0;
      end else begin
        done_q <= psum_vld_i[c] & last_pass & last_px;
        if (psum_vld_i[c]) begin
          if (last_px) begin
            px_cnt   <= '0;
            pass_cnt <= last_pass ? '0 : pass_cnt + 1'b1;
          end else begin
            px_cnt <= px_cnt + 1'b1;
          end
        end
      end
    end

    // The first pass overwrites, so stale contents after reset or clear are never summed.
    always_ff @(posedge clk_i) begin
      if (psum_vld_i[c] && !clr_i && !last_pass)
        acc[px_cnt] <= (pass_cnt == '0) ? psum : sum;
    end

    psum_col_fifo #(
      .WIDTH (FW),
      .DEPTH (G_FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (clr_i),
      .push  (fifo_push[c]),
      .pop   (fifo_pop[c]),
      .wdata ({res, px_cnt}),
      .rdata (fifo_word[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin : p_arb
    int idx;
    grant_vld = 1'b0;
    grant_col = '0;
    idx       = 0;
    for (int i = 1; i <= G_ARRAY_WIDTH; i++) begin
      idx = (int'(last_col) + i) % G_ARRAY_WIDTH;
      if (!grant_vld && !fifo_empty[COL_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_col = COL_W'(idx);
      end
    end
  end

  assign grant_word = fifo_word[grant_col];
  assign advance    = ~out_vld_q | out_rdy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_col_q  <= '0;
      out_px_q   <= '0;
      last_col   <= COL_W'(G_ARRAY_WIDTH - 1);
      ovf_q      <= 1'b0;
    end else if (clr_i) begin
      out_vld_q  <= 1'b0;
      last_col   <= COL_W'(G_ARRAY_WIDTH - 1);
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (|(fifo_push & fifo_full & ~fifo_pop));
      if (advance) begin
        out_vld_q <= grant_vld;
        if (grant_vld) begin
          out_data_q <= grant_word[FW-1:PX_W];
          out_px_q   <= grant_word[PX_W-1:0];
          out_col_q  <= grant_col;
          last_col   <= grant_col;
        end
      end
    end
  end

  assign out_vld_o  = out_vld_q;
  assign out_data_o = out_data_q;
  assign out_col_o  = out_col_q;
  assign out_px_o   = out_px_q;
  assign row_done_o = row_done;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: one single-pass instance and one three-pass instance,
// each with its own expected-output queue popped on every accepted output word.
module tb_psum_accumulator;

  localparam int W  = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  col;
    logic [4:0]  px;
  } exp_t;

  typedef logic [15:0] row_t [24];

  logic            clk = 1'b0;
  logic            rst;
  logic            clr1, clr3, rdy1, rdy3;
  logic [W-1:0]    vld1, vld3, rd1, rd3;
  logic [W*DW-1:0] psum1, psum3;
  logic            ov1, ov3, ovf1, ovf3;
  logic [DW-1:0]   od1, od3;
  logic [1:0]      oc1, oc3;
  logic [4:0]      op1, op3;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int   rdc1[W];
  int   rdc3[W];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.G_NUM_PASSES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr1), .psum_vld_i(vld1), .psum_i(psum1),
    .out_vld_o(ov1), .out_rdy_i(rdy1), .out_data_o(od1), .out_col_o(oc1), .out_px_o(op1),
    .row_done_o(rd1), .ovf_o(ovf1)
  );

  psum_accumulator #(.G_NUM_PASSES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr3), .psum_vld_i(vld3), .psum_i(psum3),
    .out_vld_o(ov3), .out_rdy_i(rdy3), .out_data_o(od3), .out_col_o(oc3), .out_px_o(op3),
    .row_done_o(rd3), .ovf_o(ovf3)
  );

  // A word is consumed at the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (ov1 === 1'b1 && rdy1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL out1_unexpected: got data=%h col=%0d px=%0d, expected no word", od1, oc1, op1);
      end else begin
        e1 = q1.pop_front();
        if ({od1, oc1, op1} !== e1) begin
          errors++;
          $display("FAIL out1_word: got data=%h col=%0d px=%0d, expected data=%h col=%0d px=%0d",
                   od1, oc1, op1, e1.data, e1.col, e1.px);
        end
      end
    end
    if (ov3 === 1'b1 && rdy3 === 1'b1) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL out3_unexpected: got data=%h col=%0d px=%0d, expected no word", od3, oc3, op3);
      end else begin
        e3 = q3.pop_front();
        if ({od3, oc3, op3} !== e3) begin
          errors++;
          $display("FAIL out3_word: got data=%h col=%0d px=%0d, expected data=%h col=%0d px=%0d",
                   od3, oc3, op3, e3.data, e3.col, e3.px);
        end
      end
    end
    for (int c = 0; c < W; c++) begin
      if (rd1[c] === 1'b1) rdc1[c]++;
      if (rd3[c] === 1'b1) rdc3[c]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic [15:0] d, input int c, input int px);
    return exp_t'{d, 2'(c), 5'(px)};
  endfunction

  function automatic logic [W*DW-1:0] lane(input int c, input logic [15:0] d);
    logic [W*DW-1:0] r;
    r = '0;
    r[c*DW +: DW] = d;
    return r;
  endfunction

  function automatic int clamp(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Three-pass reference: store, saturating add, saturating add, then ReLU.
  function automatic logic [15:0] model3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] z);
    int s;
    s = clamp(int'($signed(a)) + int'($signed(b)));
    s = clamp(s + int'($signed(z)));
    return (s < 0) ? 16'h0000 : 16'(s);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic [W-1:0] v, input logic [W*DW-1:0] p);
    vld1 = v; psum1 = p;
    @(posedge clk); #1;
    vld1 = '0;
  endtask

  task automatic drv3(input logic [W-1:0] v, input logic [W*DW-1:0] p);
    vld3 = v; psum3 = p;
    @(posedge clk); #1;
    vld3 = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (q1.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    idle(3);
  endtask

  task automatic clear_rdc();
    for (int c = 0; c < W; c++) begin
      rdc1[c] = 0;
      rdc3[c] = 0;
    end
  endtask

  task automatic feed3(input int c, input row_t a, input row_t b, input row_t z);
    for (int k = 0; k < 24; k++) drv3(4'(1 << c), lane(c, a[k]));
    for (int k = 0; k < 24; k++) drv3(4'(1 << c), lane(c, b[k]));
    for (int k = 0; k < 24; k++) begin
      q3.push_back(mk(model3(a[k], b[k], z[k]), c, k));
      drv3(4'(1 << c), lane(c, z[k]));
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ov1, ov3, ovf1, ovf3} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got vld1,vld3,ovf1,ovf3=%b, expected 0000", {ov1, ov3, ovf1, ovf3});
    end
    checks++;
    if ({od1, oc1, op1, od3, oc3, op3} !== '0) begin
      errors++;
      $display("FAIL reset_data: got od1=%h od3=%h col=%0d/%0d px=%0d/%0d, expected all 0",
               od1, od3, oc1, oc3, op1, op3);
    end
    checks++;
    if ({rd1, rd3} !== '0) begin
      errors++;
      $display("FAIL reset_row_done: got %b %b, expected 0", rd1, rd3);
    end
  endtask

  task automatic test_single_pass();
    logic [15:0] d;
    clear_rdc();
    rdy1 = 1'b1;
    for (int p = 0; p < 24; p++) begin
      d = 16'((p + 1) * 256);
      q1.push_back(mk(d, 0, p));
      drv1(4'b0001, lane(0, d));
      if (p == 0) begin
        checks++;
        if (ov1 !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: got out_vld=%b one cycle after psum, expected 0", ov1);
        end
      end
      if (p == 1) begin
        checks++;
        if (ov1 !== 1'b1 || od1 !== 16'h0100) begin
          errors++;
          $display("FAIL latency_2cyc: got vld=%b data=%h, expected vld=1 data=0100", ov1, od1);
        end
      end
    end
    wait_drain();
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got %0d words missing, expected 0", q1.size());
    end
    checks++;
    if (rdc1[0] != 1 || rdc1[1] + rdc1[2] + rdc1[3] != 0) begin
      errors++;
      $display("FAIL single_row_done: got counts %0d/%0d/%0d/%0d, expected 1/0/0/0",
               rdc1[0], rdc1[1], rdc1[2], rdc1[3]);
    end
  endtask

  task automatic test_multi_pass();
    row_t a, b, z;
    clear_rdc();
    rdy3 = 1'b1;
    for (int k = 0; k < 24; k++) begin a[k] = 16'h2000; b[k] = 16'h2000; z[k] = 16'h2000; end
    feed3(2, a, b, z);
    for (int k = 0; k < 24; k++) begin a[k] = 16'h6000; b[k] = 16'h6000; z[k] = 16'h0000; end
    feed3(2, a, b, z);
    wait_drain();
    checks++;
    if (q3.size() != 0) begin
      errors++;
      $display("FAIL multi_drain: got %0d words missing, expected 0", q3.size());
    end
    checks++;
    if (rdc3[2] != 2 || ovf3 !== 1'b0) begin
      errors++;
      $display("FAIL multi_row_done: got row_done count=%0d ovf=%b, expected 2 and 0", rdc3[2], ovf3);
    end
  endtask

  task automatic test_relu();
    row_t a, b, z;
    for (int k = 0; k < 24; k++) begin
      case (k % 3)
        0:       begin a[k] = 16'hF000; b[k] = 16'h0000; z[k] = 16'h0000; end
        1:       begin a[k] = 16'hA000; b[k] = 16'hA000; z[k] = 16'h0000; end
        default: begin a[k] = 16'h1000; b[k] = 16'h1000; z[k] = 16'h1000; end
      endcase
    end
    feed3(0, a, b, z);
    wait_drain();
    checks++;
    if (q3.size() != 0) begin
      errors++;
      $display("FAIL relu_drain: got %0d words missing, expected 0", q3.size());
    end
  endtask

  task automatic test_all_lanes();
    logic [15:0]     pa [W][24];
    logic [15:0]     pb [W][24];
    logic [15:0]     pc;
    logic [W*DW-1:0] vec;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int c = 0; c < W; c++)
      for (int k = 0; k < 24; k++) begin
        pa[c][k] = 16'($urandom_range(0, 16'hFFFF));
        pb[c][k] = 16'($urandom_range(0, 16'hFFFF));
      end
    for (int k = 0; k < 24; k++) begin
      vec = '0;
      for (int c = 0; c < W; c++) vec = vec | lane(c, pa[c][k]);
      drv3(4'hF, vec);
    end
    for (int k = 0; k < 24; k++) begin
      vec = '0;
      for (int c = 0; c < W; c++) vec = vec | lane(c, pb[c][k]);
      drv3(4'hF, vec);
    end
    for (int k = 0; k < 24; k++) begin
      vec = '0;
      for (int c = 0; c < W; c++) begin
        pc  = 16'($urandom_range(0, 16'hFFFF));
        vec = vec | lane(c, pc);
        q3.push_back(mk(model3(pa[c][k], pb[c][k], pc), c, k));
      end
      drv3(4'hF, vec);
      if (k % 2 == 1) idle(8);
    end
    wait_drain();
    checks++;
    if (q3.size() != 0) begin
      errors++;
      $display("FAIL all_lanes_drain: got %0d words missing, expected 0", q3.size());
    end
    checks++;
    if (ovf3 !== 1'b0) begin
      errors++;
      $display("FAIL all_lanes_ovf: got ovf=%b, expected 0", ovf3);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    rdy1 = 1'b0;
    q1.push_back(mk(16'h0ABC, 0, 0));
    drv1(4'b0001, lane(0, 16'h0ABC));
    idle(3);
    for (int i = 0; i < 9; i++) begin
      d = 16'(16'h1000 + i);
      if (i < 8) q1.push_back(mk(d, 1, i));
      drv1(4'b0010, lane(1, d));
    end
    idle(2);
    checks++;
    if (ovf1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b, expected 1", ovf1);
    end
    checks++;
    if (ov1 !== 1'b1 || od1 !== 16'h0ABC || oc1 !== 2'd0) begin
      errors++;
      $display("FAIL ovf_hold: got vld=%b data=%h col=%0d, expected vld=1 data=0abc col=0", ov1, od1, oc1);
    end
    rdy1 = 1'b1;
    wait_drain();
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain: got %0d words missing, expected 0", q1.size());
    end
  endtask

  task automatic test_clear();
    rdy1 = 1'b0;
    drv1(4'b0001, lane(0, 16'h0555));
    idle(3);
    checks++;
    if (ov1 !== 1'b1 || od1 !== 16'h0555) begin
      errors++;
      $display("FAIL clear_pending: got vld=%b data=%h, expected vld=1 data=0555", ov1, od1);
    end
    clr1 = 1'b1;
    drv1(4'b0001, lane(0, 16'h0777));
    clr1 = 1'b0;
    checks++;
    if (ov1 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL clear_flags: got vld=%b ovf=%b, expected 0 and 0", ov1, ovf1);
    end
    rdy1 = 1'b1;
    q1.push_back(mk(16'h0321, 0, 0));
    q1.push_back(mk(16'h0654, 1, 0));
    drv1(4'b0011, lane(0, 16'h0321) | lane(1, 16'h0654));
    wait_drain();
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL clear_drain: got %0d words missing, expected 0", q1.size());
    end
  endtask

  task automatic test_reset_mid_row();
    row_t a, b, z;
    rdy1 = 1'b0;
    drv1(4'b0001, lane(0, 16'h1234));
    idle(3);
    for (int k = 0; k < 24; k++) drv3(4'b1000, lane(3, 16'h7000));
    for (int k = 0; k < 10; k++) drv3(4'b1000, lane(3, 16'h7000));
    rst = 1'b1;
    #1;
    checks++;
    if ({ov1, ov3, ovf1, ovf3, rd1, rd3} !== '0) begin
      errors++;
      $display("FAIL rst_async_flags: got vld1=%b vld3=%b ovf=%b%b rd=%b/%b, expected all 0",
               ov1, ov3, ovf1, ovf3, rd1, rd3);
    end
    checks++;
    if ({od1, oc1, op1} !== '0) begin
      errors++;
      $display("FAIL rst_async_data: got data=%h col=%0d px=%0d, expected 0", od1, oc1, op1);
    end
    idle(2);
    rst = 1'b0;
    rdy1 = 1'b1;
    for (int k = 0; k < 24; k++) begin
      a[k] = 16'(16'h0400 + k * 16);
      b[k] = 16'h0100;
      z[k] = 16'hFE00;
    end
    feed3(3, a, b, z);
    wait_drain();
    checks++;
    if (q3.size() != 0) begin
      errors++;
      $display("FAIL rst_fresh_row: got %0d words missing, expected 0", q3.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    clr1 = 1'b0; clr3 = 1'b0;
    rdy1 = 1'b1; rdy3 = 1'b1;
    vld1 = '0; vld3 = '0;
    psum1 = '0; psum3 = '0;
    clear_rdc();
    idle(3);
    rst = 1'b0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_relu();
    test_all_lanes();
    test_overflow();
    test_clear();
    test_reset_mid_row();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
